signed_shift_mult_param: RTL and testbench

Parametrised sequential signed multiplier for W-bit two's-complement operands using shift-add, one multiplier bit per clock. Operands are converted to magnitude, the magnitudes are multiplied, and the sign is reapplied at the end. An optional fixed-point rescale (arithmetic right shift by FRAC) is applied, followed by a selectable saturate or wrap to W bits with an overflow flag. It sits beside the arithmetic blocks of the datapath and replaces the fixed 8-bit, positive-only-clamp multiplier with a start/busy/done handshake.

---
 rtl/signed_shift_mult_param.sv | 157 +++++++++++++++
 tb/tb_signed_shift_mult_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_shift_mult_param.sv
// signed_shift_mult_param
//   Sequential signed multiplier for WIDTH-bit two's-complement operands.
//   The operand magnitudes are multiplied shift-add style, one multiplier bit
//   per clock. The sign is then reapplied, the product is rescaled by an
//   arithmetic right shift of FRAC, and the result is saturated or wrapped to
//   WIDTH bits.
//
//   state | meaning
//   IDLE  | waiting for start, busy=0
//   RUN   | WIDTH shift-add steps on the magnitudes
//   FIX   | sign, rescale, range reduce; pulse done
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, sampled only while busy=0
//   sat_en  1 = saturate on overflow, 0 = wrap (latched at start)
//   a, b    signed operands (latched at start)
//   busy    operation in flight
//   done    one-cycle pulse when c/ovf update
//   c       signed result, held until the next done
//   ovf     rescaled product did not fit in WIDTH bits
module signed_shift_mult_param #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     ma_q, ma_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              sat_q, sat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  c_q, c_d;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [PW-1:0]     prod;
  logic signed [PW-1:0] scaled;
  logic              fits;
  logic [WIDTH-1:0]  sat_val;

  // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is correct as unsigned.
  assign abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  assign prod   = neg_q ? (~acc_q + PW'(1)) : acc_q;
  assign scaled = $signed(prod) >>> FRAC;

  // In range exactly when the bits from WIDTH-1 upward are a pure sign run.
  assign fits    = (&scaled[PW-1:WIDTH-1]) | ~(|scaled[PW-1:WIDTH-1]);
  assign sat_val = scaled[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ma_d    = {{WIDTH{1'b0}}, abs_a};
          mb_d    = abs_b;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          sat_d   = sat_en;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // ma is pre-shifted and mb consumed LSB first, so bit cnt of the
        // multiplier always sits in mb_q[0].
        if (mb_q[0]) acc_d = acc_q + ma_q;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (fits) begin
          c_d   = scaled[WIDTH-1:0];
          ovf_d = 1'b0;
        end else begin
          c_d   = sat_q ? sat_val : scaled[WIDTH-1:0];
          ovf_d = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      c_q     <= c_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_signed_shift_mult_param.sv
// Bench for signed_shift_mult_param: three instances (W8/F0, W8/F4, W16/F0)
// checked against an integer-arithmetic reference model.
module tb_signed_shift_mult_param;

  logic clk, rst;

  logic       start0, sat0, busy0, done0, ovf0;
  logic [7:0] a0, b0, c0;
  logic       start1, sat1, busy1, done1, ovf1;
  logic [7:0] a1, b1, c1;
  logic        start2, sat2, busy2, done2, ovf2;
  logic [15:0] a2, b2, c2;

  int checks;
  int failures;

  signed_shift_mult_param #(.WIDTH(8), .FRAC(0)) u_w8f0 (
    .clk(clk), .rst(rst), .start(start0), .sat_en(sat0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .c(c0), .ovf(ovf0));

  signed_shift_mult_param #(.WIDTH(8), .FRAC(4)) u_w8f4 (
    .clk(clk), .rst(rst), .start(start1), .sat_en(sat1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .c(c1), .ovf(ovf1));

  signed_shift_mult_param #(.WIDTH(16), .FRAC(0)) u_w16f0 (
    .clk(clk), .rst(rst), .start(start2), .sat_en(sat2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .c(c2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int which);
    return (which == 2) ? 16 : 8;
  endfunction

  function automatic int frac_of(input int which);
    return (which == 1) ? 4 : 0;
  endfunction

  // Reference: exact integer product, floor-shift, then range reduce.
  task automatic ref_mul(input int w, input int frac, input longint av,
                         input longint bv, input bit sat,
                         output longint cv, output bit ov);
    longint p, s, lo, hi, m;
    p  = av * bv;
    s  = p >>> frac;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    if (s >= lo && s <= hi) begin
      cv = s;
      ov = 1'b0;
    end else begin
      ov = 1'b1;
      if (sat) cv = (s < 0) ? lo : hi;
      else begin
        m = s & ((longint'(1) << w) - 1);
        if (m > hi) m = m - (longint'(1) << w);
        cv = m;
      end
    end
  endtask

  task automatic drive(input int which, input logic st, input longint av,
                       input longint bv, input logic sat);
    case (which)
      0: begin start0 = st; a0 = av[7:0];  b0 = bv[7:0];  sat0 = sat; end
      1: begin start1 = st; a1 = av[7:0];  b1 = bv[7:0];  sat1 = sat; end
      default: begin start2 = st; a2 = av[15:0]; b2 = bv[15:0]; sat2 = sat; end
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_ovf(input int which);
    case (which)
      0: return ovf0;
      1: return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic longint get_c(input int which);
    case (which)
      0: return longint'($signed(c0));
      1: return longint'($signed(c1));
      default: return longint'($signed(c2));
    endcase
  endfunction

  function automatic logic rbit();
    int unsigned r;
    r = $urandom_range(0, 1);
    return r[0];
  endfunction

  // One full operation; inputs are scrambled right after the start edge.
  task automatic do_op(input int which, input longint av, input longint bv,
                       input bit sat, input string tag);
    longint cv;
    bit     ov;
    int     k, busy_cnt, w;
    bit     seen;
    w = width_of(which);
    ref_mul(w, frac_of(which), av, bv, sat, cv, ov);
    @(negedge clk);
    drive(which, 1'b1, av, bv, sat);
    seen = 1'b0;
    busy_cnt = 0;
    k = 0;
    while (!seen && k < 4 * w + 10) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(which, 1'b0, longint'($urandom), longint'($urandom), rbit());
      if (get_busy(which)) busy_cnt++;
      if (get_done(which)) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, longint'(seen), 1);
    chk({tag, "_latency"}, longint'(k - 1), longint'(w + 1));
    chk({tag, "_busy_cycles"}, longint'(busy_cnt), longint'(w + 1));
    chk({tag, "_c"}, get_c(which), cv);
    chk({tag, "_ovf"}, longint'(get_ovf(which)), longint'(ov));
  endtask

  initial begin
    int  k;
    bit  seen, extra;
    longint cv;
    bit  ov;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_done", longint'(done0), 0);
    chk("rst_c", get_c(0), 0);
    chk("rst_ovf", longint'(ovf0), 0);
    rst = 1'b0;

    // Basic and corner cases on W8/F0.
    do_op(0, 5, -3, 1'b1, "t1_5x-3");
    do_op(0, -128, -128, 1'b1, "t2_sat");
    do_op(0, -128, -128, 1'b0, "t2_wrap");
    do_op(0, -128, 1, 1'b1, "t2_min_x1");
    do_op(0, 127, 127, 1'b1, "t2_pos_sat");
    do_op(0, -128, 127, 1'b0, "t2_neg_wrap");
    do_op(0, 0, -77, 1'b1, "t2_zero");

    // Fixed-point W8/F4.
    do_op(1, 24, 40, 1'b1, "t3_1p5x2p5");
    do_op(1, -1, 1, 1'b1, "t3_floor");
    do_op(1, -1, -1, 1'b1, "t3_tiny_pos");
    do_op(1, 127, 127, 1'b1, "t3_sat");
    do_op(1, -128, 127, 1'b0, "t3_wrap");

    // Start while busy is ignored; start during done is accepted.
    @(negedge clk);
    drive(0, 1'b1, 7, 9, 1'b1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(0, 1'b0, 0, 0, 1'b0);
      if (k == 3) drive(0, 1'b1, -100, 100, 1'b0);
      if (k == 4) drive(0, 1'b0, 0, 0, 1'b0);
      if (done0) seen = 1'b1;
    end
    chk("t4_first_latency", longint'(k - 1), 9);
    chk("t4_first_c", get_c(0), 63);
    chk("t4_first_ovf", longint'(ovf0), 0);
    drive(0, 1'b1, -6, 7, 1'b1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(0, 1'b0, 0, 0, 1'b0);
      if (done0) seen = 1'b1;
    end
    chk("t4_second_latency", longint'(k - 1), 9);
    chk("t4_second_c", get_c(0), -42);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    drive(0, 1'b1, 11, 11, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", longint'(busy0), 0);
    chk("t5_rst_done", longint'(done0), 0);
    chk("t5_rst_c", get_c(0), 0);
    chk("t5_rst_ovf", longint'(ovf0), 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done0 || busy0) extra = 1'b1;
    end
    chk("t5_no_done_after_rst", longint'(extra), 0);
    do_op(0, -9, 13, 1'b1, "t5_after_rst");

    // W16 corners and random sweep.
    do_op(2, -32768, -32768, 1'b1, "t6_min_sat");
    do_op(2, -32768, -32768, 1'b0, "t6_min_wrap");
    do_op(2, -32768, 1, 1'b0, "t6_min_x1");
    for (int i = 0; i < 1000; i++) begin
      int unsigned ra, rb;
      longint av, bv;
      ra = $urandom;
      rb = $urandom;
      // Mix small operands in so non-overflow results are well covered.
      if (i % 3 == 0) begin
        av = longint'($signed(ra[7:0]));
        bv = longint'($signed(rb[7:0]));
      end else begin
        av = longint'($signed(ra[15:0]));
        bv = longint'($signed(rb[15:0]));
      end
      ref_mul(16, 0, av, bv, 1'b0, cv, ov);
      do_op(2, av, bv, rbit(), "t6_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
